// File: rtl/ascon_perm_ctrl_if.sv
// Bus between the Ascon permutation controller, its requester and the round core.
// The slave modport is the controller's view; the master modport is the surrounding logic.
interface ascon_perm_ctrl_if;
  logic        start_i;
  logic [3:0]  rounds_i;
  logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
  logic        ready_o;
  logic        done_o;
  logic        err_o;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
  logic [3:0]  round_cnt_o;
  logic [63:0] px0_o, px1_o, px2_o, px3_o, px4_o;
  logic [63:0] px0_i, px1_i, px2_i, px3_i, px4_i;
  logic        sbox_wr_i;
  logic [4:0]  sbox_addr_i;
  logic [19:0] sbox_data_i;
  logic        upd_sbox_o;
  logic [4:0]  sbox_addr_o;
  logic [19:0] sbox_data_o;

  modport slave (
    input  start_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i,
           px0_i, px1_i, px2_i, px3_i, px4_i,
           sbox_wr_i, sbox_addr_i, sbox_data_i,
    output ready_o, done_o, err_o, x0_o, x1_o, x2_o, x3_o, x4_o, round_cnt_o,
           px0_o, px1_o, px2_o, px3_o, px4_o,
           upd_sbox_o, sbox_addr_o, sbox_data_o
  );

  modport master (
    output start_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i,
           px0_i, px1_i, px2_i, px3_i, px4_i,
           sbox_wr_i, sbox_addr_i, sbox_data_i,
    input  ready_o, done_o, err_o, x0_o, x1_o, x2_o, x3_o, x4_o, round_cnt_o,
           px0_o, px1_o, px2_o, px3_o, px4_o,
           upd_sbox_o, sbox_addr_o, sbox_data_o
  );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// Round-sequencing controller for an external Ascon permutation core: holds the
// 320-bit state, steps the round index and gates S-box table updates.
module ascon_perm_ctrl #(
  parameter bit SBOX_LOCK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  ascon_perm_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [4:0][63:0]  x_q;
  logic [3:0]        rc_q, rc_nxt;
  logic              load, advance, start_bad;
  logic              sbox_fwd, sbox_drop;
  logic              err_q, upd_q;
  logic [4:0]        addr_q;
  logic [19:0]       data_q;

  always_comb begin
    state_nxt = state;
    rc_nxt    = rc_q;
    load      = 1'b0;
    advance   = 1'b0;
    start_bad = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.rounds_i != 4'd0 && bus.rounds_i <= 4'd12) begin
            load      = 1'b1;
            rc_nxt    = 4'd12 - bus.rounds_i;
            state_nxt = RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      RUN: begin
        advance = 1'b1;
        if (rc_q == 4'd11) state_nxt = DONE;
        else               rc_nxt    = rc_q + 4'd1;
      end
      DONE: begin
        state_nxt = IDLE;
        rc_nxt    = '0;
      end
      default: begin
        state_nxt = IDLE;
        rc_nxt    = '0;
      end
    endcase
  end

  // A write in the same IDLE cycle as an accepted start still goes through,
  // landing at the core before the first round result is captured.
  assign sbox_fwd  = bus.sbox_wr_i && (!SBOX_LOCK || state == IDLE);
  assign sbox_drop = bus.sbox_wr_i && !sbox_fwd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rc_q   <= '0;
      x_q    <= '0;
      err_q  <= 1'b0;
      upd_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      rc_q  <= rc_nxt;
      if (load)
        x_q <= {bus.x4_i, bus.x3_i, bus.x2_i, bus.x1_i, bus.x0_i};
      else if (advance)
        x_q <= {bus.px4_i, bus.px3_i, bus.px2_i, bus.px1_i, bus.px0_i};
      err_q <= start_bad | sbox_drop;
      upd_q <= sbox_fwd;
      if (sbox_fwd) begin
        addr_q <= bus.sbox_addr_i;
        data_q <= bus.sbox_data_i;
      end
    end
  end

  assign bus.ready_o     = (state == IDLE);
  assign bus.done_o      = (state == DONE);
  assign bus.err_o       = err_q;
  assign bus.round_cnt_o = rc_q;
  assign bus.x0_o        = x_q[0];
  assign bus.x1_o        = x_q[1];
  assign bus.x2_o        = x_q[2];
  assign bus.x3_o        = x_q[3];
  assign bus.x4_o        = x_q[4];
  assign bus.px0_o       = x_q[0];
  assign bus.px1_o       = x_q[1];
  assign bus.px2_o       = x_q[2];
  assign bus.px3_o       = x_q[3];
  assign bus.px4_o       = x_q[4];
  assign bus.upd_sbox_o  = upd_q;
  assign bus.sbox_addr_o = addr_q;
  assign bus.sbox_data_o = data_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: an Ascon round core plus a transaction-level model
// checked every cycle, with directed literal checks around it.
module tb_ascon_perm_ctrl;
  localparam bit LOCK = 1'b1;

  typedef logic [4:0][63:0] st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascon_perm_ctrl_if bus();
  ascon_perm_ctrl #(.SBOX_LOCK(LOCK)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic st_t ascon_round(input st_t s, input logic [3:0] r);
    logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    logic [3:0]  hi;
    a0 = s[0]; a1 = s[1]; a2 = s[2]; a3 = s[3]; a4 = s[4];
    hi = 4'hF - r;
    a2 ^= {56'd0, hi, r};
    a0 ^= a4; a4 ^= a3; a2 ^= a1;
    t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
    a0 ^= t1; a1 ^= t2; a2 ^= t3; a3 ^= t4; a4 ^= t0;
    a1 ^= a0; a0 ^= a4; a3 ^= a2; a2 = ~a2;
    a0 ^= ror(a0, 19) ^ ror(a0, 28);
    a1 ^= ror(a1, 61) ^ ror(a1, 39);
    a2 ^= ror(a2, 1)  ^ ror(a2, 6);
    a3 ^= ror(a3, 10) ^ ror(a3, 17);
    a4 ^= ror(a4, 7)  ^ ror(a4, 41);
    return {a4, a3, a2, a1, a0};
  endfunction

  // Round core seen by the controller
  st_t core;
  always_comb core = ascon_round({bus.px4_o, bus.px3_o, bus.px2_o, bus.px1_o, bus.px0_o},
                                 bus.round_cnt_o);
  assign bus.px0_i = core[0];
  assign bus.px1_i = core[1];
  assign bus.px2_i = core[2];
  assign bus.px3_i = core[3];
  assign bus.px4_i = core[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_age counts cycles since an accepted start (0 = idle);
  // ages 1..N are the rounds, age N+1 is the result cycle.
  int          m_age, m_n;
  st_t         m_cur;
  logic        m_err, m_upd;
  logic [4:0]  m_addr;
  logic [19:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age = 0; m_n = 0; m_cur = '0;
      m_err = 1'b0; m_upd = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      automatic bit idle = (m_age == 0);
      m_err = 1'b0;
      m_upd = 1'b0;
      if (bus.sbox_wr_i) begin
        if (!LOCK || idle) begin
          m_upd = 1'b1; m_addr = bus.sbox_addr_i; m_data = bus.sbox_data_i;
        end else m_err = 1'b1;
      end
      if (idle) begin
        if (bus.start_i) begin
          if (bus.rounds_i >= 1 && bus.rounds_i <= 12) begin
            m_n   = int'(bus.rounds_i);
            m_cur = {bus.x4_i, bus.x3_i, bus.x2_i, bus.x1_i, bus.x0_i};
            m_age = 1;
          end else m_err = 1'b1;
        end
      end else if (m_age <= m_n) begin
        m_cur = ascon_round(m_cur, 4'(12 - m_n + m_age - 1));
        m_age++;
      end else begin
        m_age = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      automatic logic [3:0] e_rc = (m_age == 0) ? 4'd0 :
                                   (m_age <= m_n) ? 4'(12 - m_n + m_age - 1) : 4'd11;
      chk("ready", 64'(bus.ready_o), 64'(m_age == 0));
      chk("done", 64'(bus.done_o), 64'(m_age != 0 && m_age == m_n + 1));
      chk("err", 64'(bus.err_o), 64'(m_err));
      chk("round_cnt", 64'(bus.round_cnt_o), 64'(e_rc));
      chk("x0", bus.x0_o, m_cur[0]);
      chk("x1", bus.x1_o, m_cur[1]);
      chk("x2", bus.x2_o, m_cur[2]);
      chk("x3", bus.x3_o, m_cur[3]);
      chk("x4", bus.x4_o, m_cur[4]);
      chk("px0", bus.px0_o, m_cur[0]);
      chk("upd_sbox", 64'(bus.upd_sbox_o), 64'(m_upd));
      chk("sbox_addr", 64'(bus.sbox_addr_o), 64'(m_addr));
      chk("sbox_data", 64'(bus.sbox_data_o), 64'(m_data));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_x(input st_t x);
    bus.x0_i = x[0]; bus.x1_i = x[1]; bus.x2_i = x[2]; bus.x3_i = x[3]; bus.x4_i = x[4];
  endtask

  function automatic st_t rand_st();
    st_t s;
    for (int unsigned i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  // Issue a start and measure cycles to done_o plus the round index sequence.
  task automatic run_perm(input int n, input st_t x, input int exp_lat, input int rc0);
    int lat;
    bit seq_ok;
    lat = 0;
    seq_ok = 1'b1;
    bus.start_i = 1'b1; bus.rounds_i = 4'(n); set_x(x);
    tick();
    bus.start_i = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.done_o) break;
      if (int'(bus.round_cnt_o) != rc0 + lat - 1) seq_ok = 1'b0;
    end
    chk("done_latency", 64'(lat), 64'(exp_lat));
    chk("rc_sequence", 64'(seq_ok), 64'(1));
    tick();
  endtask

  initial begin
    bus.start_i = 1'b0; bus.rounds_i = '0; set_x('0);
    bus.sbox_wr_i = 1'b0; bus.sbox_addr_i = '0; bus.sbox_data_i = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 64'(bus.ready_o), 64'(1));
    chk("rst_done", 64'(bus.done_o), 64'(0));
    chk("rst_err", 64'(bus.err_o), 64'(0));
    chk("rst_upd", 64'(bus.upd_sbox_o), 64'(0));
    chk("rst_rc", 64'(bus.round_cnt_o), 64'(0));
    chk("rst_x0", bus.x0_o, 64'd0);
    chk("rst_x4", bus.x4_o, 64'd0);
    chk("rst_addr", 64'(bus.sbox_addr_o), 64'(0));
    chk("rst_data", 64'(bus.sbox_data_o), 64'(0));
    rst = 1'b0;

    // First edge after release accepts the start
    run_perm(12, rand_st(), 13, 0);
    run_perm(6, rand_st(), 7, 6);
    run_perm(1, '0, 2, 11);
    chk("one_round_zero_x0", bus.x0_o, 64'h000964B00000004B);

    // Illegal round counts
    for (int k = 0; k < 2; k++) begin
      bus.start_i = 1'b1; bus.rounds_i = (k == 0) ? 4'd0 : 4'd13; set_x(rand_st());
      tick();
      bus.start_i = 1'b0;
      @(negedge clk);
      chk("bad_start_err", 64'(bus.err_o), 64'(1));
      chk("bad_start_ready", 64'(bus.ready_o), 64'(1));
      @(negedge clk);
      chk("bad_start_err_pulse", 64'(bus.err_o), 64'(0));
      tick();
    end
    chk("bad_start_x0_kept", bus.x0_o, 64'h000964B00000004B);

    // S-box write during RUN is dropped, then accepted in IDLE
    bus.start_i = 1'b1; bus.rounds_i = 4'd12; set_x(rand_st());
    tick();
    bus.start_i = 1'b0;
    tick();
    bus.sbox_wr_i = 1'b1; bus.sbox_addr_i = 5'h03; bus.sbox_data_i = 20'hABCDE;
    tick();
    bus.sbox_wr_i = 1'b0;
    @(negedge clk);
    chk("locked_upd", 64'(bus.upd_sbox_o), 64'(0));
    chk("locked_err", 64'(bus.err_o), 64'(1));
    for (int i = 0; i < 30 && !bus.ready_o; i++) tick();
    chk("wait_idle", 64'(bus.ready_o), 64'(1));
    bus.sbox_wr_i = 1'b1;
    tick();
    bus.sbox_wr_i = 1'b0;
    @(negedge clk);
    chk("idle_upd", 64'(bus.upd_sbox_o), 64'(1));
    chk("idle_addr", 64'(bus.sbox_addr_o), 64'(5'h03));
    chk("idle_data", 64'(bus.sbox_data_o), 64'(20'hABCDE));
    tick();

    // Reset at round 4 aborts the run
    bus.start_i = 1'b1; bus.rounds_i = 4'd12; set_x(rand_st());
    tick();
    bus.start_i = 1'b0;
    repeat (4) tick();
    chk("pre_abort_rc", 64'(bus.round_cnt_o), 64'(4));
    rst = 1'b1;
    #1;
    chk("abort_ready", 64'(bus.ready_o), 64'(1));
    chk("abort_done", 64'(bus.done_o), 64'(0));
    chk("abort_rc", 64'(bus.round_cnt_o), 64'(0));
    chk("abort_x2", bus.x2_o, 64'd0);
    tick();
    #1;
    chk("abort_no_done", 64'(bus.done_o), 64'(0));
    rst = 1'b0;
    run_perm(12, rand_st(), 13, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.start_i     = ($urandom_range(0, 3) == 0);
      bus.rounds_i    = 4'($urandom_range(0, 14));
      set_x(rand_st());
      bus.sbox_wr_i   = ($urandom_range(0, 4) == 0);
      bus.sbox_addr_i = 5'($urandom);
      bus.sbox_data_i = 20'($urandom);
      tick();
    end
    bus.start_i = 1'b0; bus.sbox_wr_i = 1'b0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
